adc_uart_framer: RTL
====================

Name: adc_uart_framer

Overview:
Multi-channel ADC sample framer between the ADC capture block and the byte-wide UART transmitter. On a sample strobe it captures all channel samples at once and emits a framed byte stream: header, sequence number, packed sample bytes, checksum. The UART transmitter consumes the stream over a valid/ready byte handshake. NUM_CH, SAMPLE_W and the decimation ratio are parametrised, so the block serves any ADC channel count without single-byte truncation of samples.

Parameters:
NUM_CH, 2, number of ADC channels captured per frame (1..8)
SAMPLE_W, 12, bits per channel sample (1..16); bytes per sample BPS = ceil(SAMPLE_W/8)
HEADER, 8'hA5, first byte of every frame
DECIM, 1, frame is started on every DECIM-th accepted sample strobe (1..255)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
sample_data  in  NUM_CH*SAMPLE_W  channel samples; ch0 in LSBs
sample_valid  in  1  one-cycle strobe, sample_data valid
byte_data  out  8  frame byte to UART TX
byte_valid  out  1  byte_data valid
byte_ready  in  1  UART TX can take a byte; transfer = byte_valid & byte_ready
frame_busy  out  1  frame in progress (state != IDLE)
overrun_cnt  out  8  saturating count of strobes dropped while busy

Behaviour:
- Reset (sys_clk edge with sys_rst=1): state IDLE, byte_valid=0, byte_data=0, frame_busy=0, overrun_cnt=0, seq=0, decim counter=0, checksum=0. Reset mid-frame aborts the frame immediately; no further bytes are presented.
- Decimation: each sample_valid in IDLE increments the decim counter; when the counter reaches DECIM-1 (or when DECIM=1), the counter clears and the frame starts. Otherwise the strobe is discarded silently (not an overrun).
- Frame start: sample_data latched into a shadow register in the strobe cycle. The next cycle has state HDR, byte_valid=1, byte_data=HEADER. Latency is 1 cycle from strobe to first byte.
- States: IDLE -> HDR -> SEQ -> DATA -> CSUM -> IDLE. Each state advances only on a transfer. DATA iterates ch 0..NUM_CH-1; for each channel it iterates byte 0..BPS-1.
- Byte order: within a sample, little-endian (low byte first). Unused upper bits of the last byte are zero-padded.
- byte_valid stays high and byte_data stays stable from first presentation until the transfer. Between bytes within a frame there are no idle cycles: the next byte is presented in the cycle after a transfer.
- SEQ byte: current seq value. seq increments by 1 mod 256 on the CSUM transfer.
- Checksum: 8-bit sum mod 256 of every byte from HEADER through the last DATA byte. It is accumulated on transfer and sent in CSUM.
- CSUM transfer: byte_valid=0, state IDLE, frame_busy=0. A sample_valid in that same cycle counts as busy (overrun). Idle acceptance resumes the following cycle.
- Overrun: sample_valid while state != IDLE increments overrun_cnt, saturating at 255. The strobe is dropped and the shadow register is unchanged.
- Frame length is 3 + NUM_CH*BPS bytes.

Optional Feature:
ADC_FRAMER_CRC8_EN: when defined, the CSUM byte is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over the same byte range, computed byte-serially on transfer. When undefined, the CSUM byte is the 8-bit additive sum. The frame length and timing are identical in both builds.

Test Plan:
- Basic frame, NUM_CH=2, SAMPLE_W=12, byte_ready=1, strobe with ch0=0x123, ch1=0xABC -> bytes A5,00,23,01,BC,0A,8F on 7 consecutive cycles starting 1 cycle after the strobe. frame_busy falls after 8F.
- Backpressure: same stimulus with byte_ready toggling 0/1 per cycle -> identical byte sequence. Each byte is held stable while byte_ready=0. No byte is duplicated or skipped.
- Overrun and seq: 3 strobes 2 cycles apart during one frame -> overrun_cnt=3. The next idle strobe produces a frame with SEQ byte 01. 300 busy strobes -> overrun_cnt saturates at FF.
- Decimation, DECIM=4: 8 strobes spaced wider than one frame -> exactly 2 frames, started by strobes 4 and 8. overrun_cnt=0.
- Reset mid-frame: assert sys_rst after the SEQ byte -> next cycle byte_valid=0, frame_busy=0, overrun_cnt=0. The next strobe's frame carries SEQ=00.
- ADC_FRAMER_CRC8_EN build: NUM_CH=1, SAMPLE_W=8, sample 0x00, seq 0 -> bytes A5,00,00 then the CRC-8 of {A5,00,00} (value precomputed by the bench reference model).

Source files
------------

// File: rtl/adc_uart_framer_if.sv
// Sample-in / byte-out handshake bundle for adc_uart_framer.
// master = framer side, slave = ADC capture + UART TX side.
interface adc_uart_framer_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 12
);
  logic [NUM_CH*SAMPLE_W-1:0] sample_data;
  logic                       sample_valid;
  logic [7:0]                 byte_data;
  logic                       byte_valid;
  logic                       byte_ready;

  modport master (
    input  sample_data, sample_valid, byte_ready,
    output byte_data, byte_valid
  );

  modport slave (
    output sample_data, sample_valid, byte_ready,
    input  byte_data, byte_valid
  );
endinterface

// File: rtl/adc_uart_framer.sv
// Multi-channel ADC sample framer: HEADER, SEQ, packed samples, checksum over a byte handshake.
// Define ADC_FRAMER_CRC8_EN to replace the additive checksum with CRC-8 (poly 0x07).
module adc_uart_framer #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 12,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned DECIM    = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  adc_uart_framer_if.master   bus,
  output logic                frame_busy,
  output logic [7:0]          overrun_cnt
);
  localparam int unsigned BPS  = (SAMPLE_W + 7) / 8;
  localparam int unsigned PADW = BPS * 8;

  typedef enum logic [2:0] {StIdle, StHdr, StSeq, StData, StCsum} state_e;

  state_e                     state_q, state_d;
  logic [NUM_CH*SAMPLE_W-1:0] shadow_q, shadow_d;
  logic [7:0]                 seq_q, seq_d;
  logic [7:0]                 decim_q, decim_d;
  logic [7:0]                 csum_q, csum_d;
  logic [7:0]                 overrun_q, overrun_d;
  logic [2:0]                 ch_q, ch_d;
  logic                       byte_idx_q, byte_idx_d;

  logic                       xfer;
  logic [SAMPLE_W-1:0]        cur_sample;
  logic [PADW-1:0]            cur_padded;
  logic [7:0]                 data_byte;
  logic [7:0]                 out_byte;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef ADC_FRAMER_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc + b;
`endif
  endfunction

  // Select the current channel and byte with constant indices only.
  always_comb begin
    cur_sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 3'(c)) cur_sample = shadow_q[c*SAMPLE_W +: SAMPLE_W];
    end
    cur_padded = PADW'(cur_sample);
    data_byte  = '0;
    for (int b = 0; b < BPS; b++) begin
      if (byte_idx_q == 1'(b)) data_byte = cur_padded[b*8 +: 8];
    end
  end

  always_comb begin
    case (state_q)
      StHdr:   out_byte = HEADER;
      StSeq:   out_byte = seq_q;
      StData:  out_byte = data_byte;
      StCsum:  out_byte = csum_q;
      default: out_byte = 8'h00;
    endcase
  end

  assign bus.byte_data  = out_byte;
  assign bus.byte_valid = (state_q != StIdle);
  assign frame_busy     = (state_q != StIdle);
  assign overrun_cnt    = overrun_q;
  assign xfer           = bus.byte_valid & bus.byte_ready;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    seq_d      = seq_q;
    decim_d    = decim_q;
    csum_d     = csum_q;
    overrun_d  = overrun_q;
    ch_d       = ch_q;
    byte_idx_d = byte_idx_q;

    // The CSUM transfer cycle still counts as busy.
    if (bus.sample_valid && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (bus.sample_valid) begin
          if ((DECIM <= 1) || (decim_q == 8'(DECIM - 1))) begin
            decim_d    = '0;
            shadow_d   = bus.sample_data;
            csum_d     = '0;
            ch_d       = '0;
            byte_idx_d = 1'b0;
            state_d    = StHdr;
          end else begin
            decim_d = decim_q + 8'd1;
          end
        end
      end
      StHdr: begin
        if (xfer) begin
          csum_d  = csum_step(csum_q, out_byte);
          state_d = StSeq;
        end
      end
      StSeq: begin
        if (xfer) begin
          csum_d  = csum_step(csum_q, out_byte);
          state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_step(csum_q, out_byte);
          if (byte_idx_q == 1'(BPS - 1)) begin
            byte_idx_d = 1'b0;
            if (ch_q == 3'(NUM_CH - 1)) begin
              state_d = StCsum;
            end else begin
              ch_d = ch_q + 3'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          seq_d   = seq_q + 8'd1;
          csum_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      seq_q      <= '0;
      decim_q    <= '0;
      csum_q     <= '0;
      overrun_q  <= '0;
      ch_q       <= '0;
      byte_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      seq_q      <= seq_d;
      decim_q    <= decim_d;
      csum_q     <= csum_d;
      overrun_q  <= overrun_d;
      ch_q       <= ch_d;
      byte_idx_q <= byte_idx_d;
    end
  end
endmodule
